// File: rtl/ps2_kbd_tx.sv
// Device-side PS/2 keyboard transmitter.
// Accepts one ASCII character per valid/ready handshake, looks up its set-2
// make code and sends the keystroke (make, F0, make) as three device-to-host
// frames. Each frame is 11 bits: start 0, data LSB first, odd parity, stop 1.
// ps2_data changes at the start of a bit's high clock phase, so it is stable
// across the falling edge where the host samples it.
// Handshake: a character is taken on a rising edge where in_valid and in_ready
// are both high. in_ready is high exactly when busy is low. in_valid is
// ignored while busy.
module ps2_kbd_tx #(
    parameter int CLK_HALF  = 50,
    parameter int FRAME_GAP = 100
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       in_valid,
    input  logic [7:0] in_ascii,
    output logic       in_ready,
    output logic       busy,
    output logic       err,
    output logic       ps2_clk,
    output logic       ps2_data
);

    localparam int HW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
    localparam int GW = (FRAME_GAP > 1) ? $clog2(FRAME_GAP) : 1;
    localparam logic [HW-1:0] HALF_LAST = HW'(CLK_HALF - 1);
    localparam logic [GW-1:0] GAP_LAST  = GW'(FRAME_GAP - 1);
    localparam logic [3:0]    BIT_LAST  = 4'd10;
    localparam logic [1:0]    FRAME_LAST = 2'd2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SHIFT = 2'd1,
        ST_GAP   = 2'd2
    } state_t;

    // Returns {mapped, make_code} for an ASCII character.
    function automatic logic [8:0] map_ascii(input logic [7:0] a);
        logic [8:0] r;
        r = 9'h000;
        case (a)
            8'h51: r = {1'b1, 8'h15};  // Q
            8'h57: r = {1'b1, 8'h1D};  // W
            8'h45: r = {1'b1, 8'h24};  // E
            8'h52: r = {1'b1, 8'h2D};  // R
            8'h54: r = {1'b1, 8'h2C};  // T
            8'h59: r = {1'b1, 8'h35};  // Y
            8'h55: r = {1'b1, 8'h3C};  // U
            8'h49: r = {1'b1, 8'h43};  // I
            8'h4F: r = {1'b1, 8'h44};  // O
            8'h50: r = {1'b1, 8'h4D};  // P
            8'h5B: r = {1'b1, 8'h54};  // [
            8'h5D: r = {1'b1, 8'h5B};  // ]
            8'h41: r = {1'b1, 8'h1C};  // A
            8'h53: r = {1'b1, 8'h1B};  // S
            8'h44: r = {1'b1, 8'h23};  // D
            8'h46: r = {1'b1, 8'h2B};  // F
            8'h47: r = {1'b1, 8'h34};  // G
            8'h48: r = {1'b1, 8'h33};  // H
            8'h4A: r = {1'b1, 8'h3B};  // J
            8'h4B: r = {1'b1, 8'h42};  // K
            8'h4C: r = {1'b1, 8'h4B};  // L
            8'h3B: r = {1'b1, 8'h4C};  // ;
            8'h22: r = {1'b1, 8'h52};  // "
            8'h5A: r = {1'b1, 8'h1A};  // Z
            8'h58: r = {1'b1, 8'h22};  // X
            8'h43: r = {1'b1, 8'h21};  // C
            8'h56: r = {1'b1, 8'h2A};  // V
            8'h42: r = {1'b1, 8'h32};  // B
            8'h4E: r = {1'b1, 8'h31};  // N
            8'h4D: r = {1'b1, 8'h3A};  // M
            8'h2C: r = {1'b1, 8'h41};  // ,
            8'h2E: r = {1'b1, 8'h49};  // .
            8'h2F: r = {1'b1, 8'h4A};  // /
            8'h20: r = {1'b1, 8'h29};  // space
            default: r = 9'h000;
        endcase
        return r;
    endfunction

    // Line level for bit position idx (0 = start .. 10 = stop) of a frame.
    function automatic logic frame_bit(input logic [3:0] idx, input logic [7:0] b);
        logic v;
        v = 1'b1;
        if (idx == 4'd0) begin
            v = 1'b0;
        end else if (idx <= 4'd8) begin
            v = b[3'(idx - 4'd1)];
        end else if (idx == 4'd9) begin
            v = ~^b;
        end
        return v;
    endfunction

    state_t        state_q, state_n;
    logic [1:0]    frame_q, frame_n;
    logic [3:0]    bit_q, bit_n;
    logic          phase_q, phase_n;   // 0: clock high half, 1: clock low half
    logic [HW-1:0] half_q, half_n;
    logic [GW-1:0] gap_q, gap_n;
    logic [7:0]    code_q, code_n;
    logic          clk_q, clk_n;
    logic          data_q, data_n;
    logic          busy_q, busy_n;
    logic          ready_q, ready_n;
    logic          err_q, err_n;

    logic [8:0]    map_w;
    logic [7:0]    byte_w;

    assign map_w  = map_ascii(in_ascii);
    // Frame 1 is the break prefix; frames 0 and 2 carry the make code.
    assign byte_w = (frame_q == 2'd1) ? 8'hF0 : code_q;

    // State and registered outputs; reset forces idle lines at once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= ST_IDLE;
            frame_q <= 2'd0;
            bit_q   <= 4'd0;
            phase_q <= 1'b0;
            half_q  <= '0;
            gap_q   <= '0;
            code_q  <= 8'h00;
            clk_q   <= 1'b1;
            data_q  <= 1'b1;
            busy_q  <= 1'b0;
            ready_q <= 1'b1;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_n;
            frame_q <= frame_n;
            bit_q   <= bit_n;
            phase_q <= phase_n;
            half_q  <= half_n;
            gap_q   <= gap_n;
            code_q  <= code_n;
            clk_q   <= clk_n;
            data_q  <= data_n;
            busy_q  <= busy_n;
            ready_q <= ready_n;
            err_q   <= err_n;
        end
    end

    // Next-state and next-output logic for the keystroke sequencer.
    always_comb begin
        state_n = state_q;
        frame_n = frame_q;
        bit_n   = bit_q;
        phase_n = phase_q;
        half_n  = half_q;
        gap_n   = gap_q;
        code_n  = code_q;
        clk_n   = clk_q;
        data_n  = data_q;
        busy_n  = busy_q;
        ready_n = ready_q;
        err_n   = 1'b0;

        case (state_q)
            ST_IDLE: begin
                clk_n  = 1'b1;
                data_n = 1'b1;
                if (in_valid && ready_q) begin
                    if (map_w[8]) begin
                        state_n = ST_SHIFT;
                        code_n  = map_w[7:0];
                        frame_n = 2'd0;
                        bit_n   = 4'd0;
                        phase_n = 1'b0;
                        half_n  = '0;
                        data_n  = 1'b0;
                        busy_n  = 1'b1;
                    end else begin
                        err_n = 1'b1;
                    end
                end
            end

            ST_SHIFT: begin
                if (half_q == HALF_LAST) begin
                    half_n = '0;
                    if (!phase_q) begin
                        phase_n = 1'b1;
                        clk_n   = 1'b0;
                    end else begin
                        phase_n = 1'b0;
                        clk_n   = 1'b1;
                        if (bit_q == BIT_LAST) begin
                            state_n = ST_GAP;
                            bit_n   = 4'd0;
                            gap_n   = '0;
                            data_n  = 1'b1;
                        end else begin
                            bit_n  = bit_q + 4'd1;
                            data_n = frame_bit(bit_q + 4'd1, byte_w);
                        end
                    end
                end else begin
                    half_n = half_q + 1'b1;
                end
            end

            ST_GAP: begin
                clk_n  = 1'b1;
                data_n = 1'b1;
                half_n = '0;
                bit_n  = 4'd0;
                if (gap_q == GAP_LAST) begin
                    gap_n = '0;
                    if (frame_q == FRAME_LAST) begin
                        state_n = ST_IDLE;
                        frame_n = 2'd0;
                        busy_n  = 1'b0;
                    end else begin
                        state_n = ST_SHIFT;
                        frame_n = frame_q + 2'd1;
                        phase_n = 1'b0;
                        data_n  = 1'b0;
                    end
                end else begin
                    gap_n = gap_q + 1'b1;
                end
            end

            default: begin
                state_n = ST_IDLE;
                clk_n   = 1'b1;
                data_n  = 1'b1;
                busy_n  = 1'b0;
            end
        endcase

        ready_n = ~busy_n;
    end

    assign in_ready = ready_q;
    assign busy     = busy_q;
    assign err      = err_q;
    assign ps2_clk  = clk_q;
    assign ps2_data = data_q;

endmodule

// File: tb/tb_ps2_kbd_tx.sv
// Bench for ps2_kbd_tx: a cycle-level waveform model built from the frame
// format, a falling-edge frame decoder, and directed keystroke scenarios.
module tb_ps2_kbd_tx;

    localparam int H = 2;
    localparam int G = 4;
    localparam int KEY_CYC = 3 * (22 * H + G);

    logic       clk;
    logic       rst;
    logic       in_valid;
    logic [7:0] in_ascii;
    logic       in_ready;
    logic       busy;
    logic       err;
    logic       ps2_clk;
    logic       ps2_data;

    int checks;
    int errors;
    int cmp_checks;
    int cmp_errors;

    ps2_kbd_tx #(.CLK_HALF(H), .FRAME_GAP(G)) dut (
        .clk      (clk),
        .rst      (rst),
        .in_valid (in_valid),
        .in_ascii (in_ascii),
        .in_ready (in_ready),
        .busy     (busy),
        .err      (err),
        .ps2_clk  (ps2_clk),
        .ps2_data (ps2_data)
    );

    // ---------------- clock ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // ---------------- key table ----------------
    logic [7:0] asc_tab [34] = '{
        8'h51, 8'h57, 8'h45, 8'h52, 8'h54, 8'h59, 8'h55, 8'h49, 8'h4F, 8'h50, 8'h5B, 8'h5D,
        8'h41, 8'h53, 8'h44, 8'h46, 8'h47, 8'h48, 8'h4A, 8'h4B, 8'h4C, 8'h3B, 8'h22,
        8'h5A, 8'h58, 8'h43, 8'h56, 8'h42, 8'h4E, 8'h4D, 8'h2C, 8'h2E, 8'h2F, 8'h20};
    logic [7:0] code_tab [34] = '{
        8'h15, 8'h1D, 8'h24, 8'h2D, 8'h2C, 8'h35, 8'h3C, 8'h43, 8'h44, 8'h4D, 8'h54, 8'h5B,
        8'h1C, 8'h1B, 8'h23, 8'h2B, 8'h34, 8'h33, 8'h3B, 8'h42, 8'h4B, 8'h4C, 8'h52,
        8'h1A, 8'h22, 8'h21, 8'h2A, 8'h32, 8'h31, 8'h3A, 8'h41, 8'h49, 8'h4A, 8'h29};

    function automatic bit is_mapped(input logic [7:0] a);
        for (int i = 0; i < 34; i++) if (asc_tab[i] == a) return 1'b1;
        return 1'b0;
    endfunction

    function automatic logic [7:0] code_of(input logic [7:0] a);
        for (int i = 0; i < 34; i++) if (asc_tab[i] == a) return code_tab[i];
        return 8'h00;
    endfunction

    // ---------------- waveform model ----------------
    // Each entry is the expected {ps2_clk, ps2_data, busy} for one cycle.
    logic [2:0] exp_q[$];
    logic [2:0] cur_exp;
    logic       err_exp;

    task automatic push_keystroke(input logic [7:0] make);
        logic [7:0]  b;
        logic [10:0] fr;
        for (int f = 0; f < 3; f++) begin
            b  = (f == 1) ? 8'hF0 : make;
            fr = {1'b1, ~^b, b, 1'b0};
            for (int k = 0; k < 11; k++) begin
                repeat (H) exp_q.push_back({1'b1, fr[k], 1'b1});
                repeat (H) exp_q.push_back({1'b0, fr[k], 1'b1});
            end
            repeat (G) exp_q.push_back(3'b111);
        end
    endtask

    always @(posedge clk or posedge rst) begin
        if (rst) begin
            exp_q.delete();
            cur_exp <= 3'b110;
            err_exp <= 1'b0;
        end else begin
            if (in_valid && !cur_exp[0]) begin
                if (is_mapped(in_ascii)) push_keystroke(code_of(in_ascii));
                err_exp <= !is_mapped(in_ascii);
            end else begin
                err_exp <= 1'b0;
            end
            if (exp_q.size() > 0) cur_exp <= exp_q.pop_front();
            else cur_exp <= 3'b110;
        end
    end

    // ---------------- per-cycle compare ----------------
    int cyc;
    initial begin
        cyc = 0;
        cmp_checks = 0;
        cmp_errors = 0;
    end

    always @(negedge clk) begin
        cyc <= cyc + 1;
        cmp_checks <= cmp_checks + 1;
        if ({ps2_clk, ps2_data, busy, in_ready, err} !== {cur_exp, ~cur_exp[0], err_exp}) begin
            cmp_errors <= cmp_errors + 1;
            $display("FAIL cycle %0d clk/data/busy/ready/err: got %b%b%b%b%b expected %b%b%b%b%b",
                     cyc, ps2_clk, ps2_data, busy, in_ready, err,
                     cur_exp[2], cur_exp[1], cur_exp[0], ~cur_exp[0], err_exp);
        end
    end

    // ---------------- frame decoder and activity counters ----------------
    logic [10:0] rx_q[$];
    logic [10:0] rx_sh;
    int          rx_n;
    logic        prev_clk;
    int          busy_cyc;
    int          err_cyc;
    int          low_ready_cyc;
    int          fall_cnt;

    initial begin
        busy_cyc      = 0;
        err_cyc       = 0;
        low_ready_cyc = 0;
        fall_cnt      = 0;
    end

    always @(negedge clk or posedge rst) begin
        if (rst) begin
            rx_n     <= 0;
            rx_sh    <= '0;
            prev_clk <= 1'b1;
        end else begin
            prev_clk <= ps2_clk;
            if (busy) busy_cyc <= busy_cyc + 1;
            if (err) err_cyc <= err_cyc + 1;
            if (!in_ready) low_ready_cyc <= low_ready_cyc + 1;
            if (prev_clk && !ps2_clk) begin
                fall_cnt <= fall_cnt + 1;
                if (rx_n == 10) begin
                    rx_q.push_back({ps2_data, rx_sh[10:1]});
                    rx_n <= 0;
                end else begin
                    rx_sh <= {ps2_data, rx_sh[10:1]};
                    rx_n  <= rx_n + 1;
                end
            end
        end
    end

    // ---------------- driver and check tasks ----------------
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, req);
        end
    endtask

    task automatic send_char(input logic [7:0] a);
        @(negedge clk);
        in_valid = 1'b1;
        in_ascii = a;
        @(negedge clk);
        in_valid = 1'b0;
    endtask

    task automatic wait_busy(input logic lvl, input int limit, input string what);
        int n;
        n = 0;
        while (busy !== lvl && n < limit) begin
            @(negedge clk);
            n++;
        end
        if (busy !== lvl) begin
            checks++;
            errors++;
            $display("FAIL timeout %s: busy %b expected %b", what, busy, lvl);
        end
    endtask

    task automatic check_frame(input string name, input int idx, input logic [10:0] req);
        logic [10:0] got;
        got = (idx < rx_q.size()) ? rx_q[idx] : 11'h000;
        check(name, {21'd0, got}, {21'd0, req});
    endtask

    task automatic check_idle_lines(input string tag);
        check({tag, " ps2_clk"}, {31'd0, ps2_clk}, 32'd1);
        check({tag, " ps2_data"}, {31'd0, ps2_data}, 32'd1);
        check({tag, " in_ready"}, {31'd0, in_ready}, 32'd1);
        check({tag, " busy"}, {31'd0, busy}, 32'd0);
        check({tag, " err"}, {31'd0, err}, 32'd0);
    endtask

    // ---------------- watchdog ----------------
    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- directed scenarios ----------------
    initial begin
        int base, b0, e0, f0, r0;
        logic [7:0]  c;
        logic [10:0] fm, fb;
        checks   = 0;
        errors   = 0;
        rst      = 1'b1;
        in_valid = 1'b0;
        in_ascii = 8'h00;
        repeat (3) @(negedge clk);
        check_idle_lines("reset");
        rst = 1'b0;
        @(negedge clk);

        // 'A' -> 1C F0 1C, busy exactly 3*(22*2+4)=144 cycles
        base = rx_q.size();
        b0   = busy_cyc;
        send_char(8'h41);
        check("A start bit", {31'd0, ps2_data}, 32'd0);
        check("A ready low", {31'd0, in_ready}, 32'd0);
        wait_busy(1'b0, 1000, "A done");
        check("A busy cycles", busy_cyc - b0, 32'd144);
        check("A frame count", rx_q.size() - base, 32'd3);
        check_frame("A make", base + 0, 11'h438);
        check_frame("A break", base + 1, 11'h7E0);
        check_frame("A make2", base + 2, 11'h438);

        // 'a' unmapped, then 'S' on the very next edge
        base = rx_q.size();
        e0 = err_cyc;
        f0 = fall_cnt;
        r0 = low_ready_cyc;
        @(negedge clk);
        in_valid = 1'b1;
        in_ascii = 8'h61;
        @(negedge clk);
        check("a err pulse", {31'd0, err}, 32'd1);
        check("a ready kept", low_ready_cyc - r0, 32'd0);
        check("a no clock", fall_cnt - f0, 32'd0);
        check("a data high", {31'd0, ps2_data}, 32'd1);
        in_ascii = 8'h53;
        @(negedge clk);
        in_valid = 1'b0;
        check("S err clear", {31'd0, err}, 32'd0);
        check("S accepted", {31'd0, busy}, 32'd1);
        wait_busy(1'b0, 1000, "S done");
        check("a err cycles", err_cyc - e0, 32'd1);
        check_frame("S make", base + 0, 11'h636);
        check_frame("S break", base + 1, 11'h7E0);
        check_frame("S make2", base + 2, 11'h636);

        // 'Q' then ' ' held on in_valid: back-to-back keystrokes
        base = rx_q.size();
        @(negedge clk);
        in_valid = 1'b1;
        in_ascii = 8'h51;
        wait_busy(1'b1, 10, "Q start");
        in_ascii = 8'h20;
        wait_busy(1'b0, 1000, "Q done");
        check("Q ready between", {31'd0, in_ready}, 32'd1);
        @(negedge clk);
        check("space back-to-back", {31'd0, busy}, 32'd1);
        in_valid = 1'b0;
        wait_busy(1'b0, 1000, "space done");
        check("Q/space frame count", rx_q.size() - base, 32'd6);
        check_frame("Q make", base + 0, 11'h42A);
        check_frame("Q break", base + 1, 11'h7E0);
        check_frame("Q make2", base + 2, 11'h42A);
        check_frame("space make", base + 3, 11'h452);
        check_frame("space break", base + 4, 11'h7E0);
        check_frame("space make2", base + 5, 11'h452);

        // reset during bit 5 of the F0 frame of 'Z'
        base = rx_q.size();
        send_char(8'h5A);
        repeat (68) @(negedge clk);
        check("Z mid busy", {31'd0, busy}, 32'd1);
        check("Z F0 bit5 data", {31'd0, ps2_data}, 32'd1);
        #2;
        rst = 1'b1;
        #1;
        check_idle_lines("mid-frame reset");
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("Z partial frames", rx_q.size() - base, 32'd1);
        @(negedge clk);
        base = rx_q.size();
        send_char(8'h5A);
        wait_busy(1'b0, 1000, "Z done");
        check("Z frame count", rx_q.size() - base, 32'd3);
        check_frame("Z make", base + 0, 11'h434);
        check_frame("Z break", base + 1, 11'h7E0);
        check_frame("Z make2", base + 2, 11'h434);

        // every mapped character
        for (int i = 0; i < 34; i++) begin
            base = rx_q.size();
            b0   = busy_cyc;
            c    = code_tab[i];
            fm   = {1'b1, ~^c, c, 1'b0};
            fb   = {1'b1, 1'b1, 8'hF0, 1'b0};
            send_char(asc_tab[i]);
            wait_busy(1'b0, 1000, "sweep done");
            check("sweep busy cycles", busy_cyc - b0, KEY_CYC);
            check_frame("sweep make", base + 0, fm);
            check_frame("sweep break", base + 1, fb);
            check_frame("sweep make2", base + 2, fm);
        end

        repeat (5) @(negedge clk);
        checks = checks + cmp_checks;
        errors = errors + cmp_errors;
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
